// File: rtl/bram_tree_pkg.sv
// Shared types for the bram_tree access arbiter: tree operation codes,
// arbiter FSM states and the default post-strobe idle gap.
package bram_tree_pkg;

  typedef enum logic [1:0] {
    OP_ENQ  = 2'd0,
    OP_DEQ  = 2'd1,
    OP_REPL = 2'd2,
    OP_RSVD = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam int OP_GAP_DEFAULT = 24;

  // An op may only reach the tree if the tree can honour it right now.
  function automatic logic op_legal(op_t op, logic full, logic empty);
    logic ok;
    case (op)
      OP_ENQ:  ok = !full;
      OP_DEQ:  ok = !empty;
      OP_REPL: ok = !empty;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: searches upward from the requester after last,
// wrapping, and returns a one-hot grant (all zero when nobody requests).
module rr_arbiter #(
  parameter int N  = 4,
  parameter int LW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [LW-1:0] last,
  output logic [N-1:0]  grant
);

  logic [LW-1:0] idx;
  logic          found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = LW'((int'(last) + k) % N);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bram_tree_arbiter.sv
// Shares one bram_tree among NUM_REQ requesters: accept one request, issue a
// single tree strobe, hold off OP_GAP cycles, then return a one-cycle response.
// Handshake: o_req_ready[g] is a one-cycle accept strobe raised only in IDLE;
// a requester keeps i_req_valid and its op/data stable until it sees it.
// o_rsp_valid is a one-cycle strobe with no backpressure.
module bram_tree_arbiter
  import bram_tree_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int OP_GAP     = OP_GAP_DEFAULT
) (
  input  logic                          CLK,
  input  logic                          RSTn,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [2*NUM_REQ-1:0]          i_req_op,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic [NUM_REQ-1:0]            o_rsp_valid,
  output logic                          o_rsp_ok,
  output logic [DATA_WIDTH-1:0]         o_rsp_data,
  output logic                          o_q_wrt,
  output logic                          o_q_read,
  output logic [DATA_WIDTH-1:0]         o_q_data,
  input  logic                          i_q_full,
  input  logic                          i_q_empty,
  input  logic [DATA_WIDTH-1:0]         i_q_data,
  output logic                          o_busy,
  output logic [1:0]                    o_dbg_state
);

  localparam int LW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(OP_GAP + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OP_GAP - 1);

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [LW-1:0]          last_q, last_d;
  logic [NUM_REQ-1:0]     grant_q, grant_d;
  op_t                    op_q, op_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic                   ok_q, ok_d;
  logic [DATA_WIDTH-1:0]  rsp_data_q, rsp_data_d;

  logic [NUM_REQ-1:0]     grant;
  logic [LW-1:0]          grant_idx;
  op_t                    sel_op;
  logic [DATA_WIDTH-1:0]  sel_data;
  logic                   legal;
  logic                   issue_go;

  rr_arbiter #(.N(NUM_REQ), .LW(LW)) u_rr (
    .req   (i_req_valid),
    .last  (last_q),
    .grant (grant)
  );

  always_comb begin
    grant_idx = '0;
    sel_op    = OP_ENQ;
    sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        grant_idx = LW'(i);
        sel_op    = op_t'(i_req_op[2*i +: 2]);
        sel_data  = i_req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign legal    = op_legal(op_q, i_q_full, i_q_empty);
  assign issue_go = (state_q == ST_ISSUE) && legal;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    grant_d    = grant_q;
    op_d       = op_q;
    data_d     = data_q;
    ok_d       = ok_q;
    rsp_data_d = rsp_data_q;
    case (state_q)
      ST_IDLE: begin
        if (|i_req_valid) begin
          grant_d = grant;
          last_d  = grant_idx;
          op_d    = sel_op;
          data_d  = sel_data;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        ok_d       = legal;
        rsp_data_d = (legal && op_q != OP_ENQ) ? i_q_data : '0;
        cnt_d      = '0;
        state_d    = legal ? ST_WAIT : ST_RESP;
      end
      ST_WAIT: begin
        // Saturate rather than wrap; exit after exactly OP_GAP cycles here.
        if (cnt_q >= CNT_LAST) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      last_q     <= LW'(NUM_REQ - 1);
      grant_q    <= '0;
      op_q       <= OP_ENQ;
      data_q     <= '0;
      ok_q       <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      grant_q    <= grant_d;
      op_q       <= op_d;
      data_q     <= data_d;
      ok_q       <= ok_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  assign o_req_ready = (RSTn && state_q == ST_IDLE) ? grant : '0;
  assign o_q_wrt     = issue_go && (op_q == OP_ENQ || op_q == OP_REPL);
  assign o_q_read    = issue_go && (op_q == OP_DEQ || op_q == OP_REPL);
  assign o_q_data    = (state_q == ST_ISSUE) ? data_q : '0;
  assign o_rsp_valid = (state_q == ST_RESP) ? grant_q : '0;
  assign o_rsp_ok    = (state_q == ST_RESP) && ok_q;
  assign o_rsp_data  = (state_q == ST_RESP) ? rsp_data_q : '0;
  assign o_busy      = (state_q != ST_IDLE);
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_bram_tree_arbiter.sv
// Bench for bram_tree_arbiter: transaction-level timeline model plus
// directed scenarios with literal expectations and a randomized soak.
module tb_bram_tree_arbiter;

  localparam int N   = 4;
  localparam int DW  = 16;
  localparam int GAP = 24;

  logic            clk;
  logic            rstn;
  logic [N-1:0]    req_valid;
  logic [2*N-1:0]  req_op;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic            rsp_ok;
  logic [DW-1:0]   rsp_data;
  logic            q_wrt, q_read;
  logic [DW-1:0]   q_data_out;
  logic            q_full, q_empty;
  logic [DW-1:0]   q_root;
  logic            busy;
  logic [1:0]      dbg_state;

  bram_tree_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .OP_GAP(GAP)) dut (
    .CLK         (clk),
    .RSTn        (rstn),
    .i_req_valid (req_valid),
    .i_req_op    (req_op),
    .i_req_data  (req_data),
    .o_req_ready (req_ready),
    .o_rsp_valid (rsp_valid),
    .o_rsp_ok    (rsp_ok),
    .o_rsp_data  (rsp_data),
    .o_q_wrt     (q_wrt),
    .o_q_read    (q_read),
    .o_q_data    (q_data_out),
    .i_q_full    (q_full),
    .i_q_empty   (q_empty),
    .i_q_data    (q_root),
    .o_busy      (busy),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // model: one outstanding transaction described by its timeline
  bit            m_active;
  int            m_last;
  int            m_g, m_op, m_acc, m_resp;
  logic [DW-1:0] m_data;
  bit            m_ok;
  logic [DW-1:0] exp_q[$];

  // snapshot of the most recently compared cycle
  logic [N-1:0]  s_ready, s_rv;
  logic          s_wrt, s_read, s_ok, s_busy;
  logic [DW-1:0] s_qdata, s_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  function automatic int op_of(int i);
    logic [2*N-1:0] v;
    v = req_op >> (2*i);
    return int'(v[1:0]);
  endfunction

  function automatic logic [DW-1:0] data_of(int i);
    logic [N*DW-1:0] v;
    v = req_data >> (DW*i);
    return v[DW-1:0];
  endfunction

  function automatic int onehot_idx(logic [N-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic model_cycle();
    logic [N-1:0]  e_ready, e_rv;
    logic          e_wrt, e_read, e_ok;
    logic [DW-1:0] e_qdata, e_rd;
    bit            legal, done, accept;
    int            w;
    e_ready = '0; e_rv = '0; e_wrt = 0; e_read = 0; e_ok = 0;
    e_qdata = '0; e_rd = '0; done = 0; accept = 0; w = -1;
    if (!rstn) begin
      chk("ready_in_reset", req_ready, 0);
      m_active = 0;
      m_last   = N - 1;
      exp_q.delete();
    end else begin
      if (!m_active) begin
        for (int k = 1; k <= N; k++) begin
          if (w < 0 && req_valid[(m_last + k) % N]) w = (m_last + k) % N;
        end
        if (w >= 0) begin
          e_ready = N'(1) << w;
          accept  = 1;
        end
      end else begin
        if (cyc == m_acc + 1) begin
          legal = (m_op == 0) ? !q_full : (m_op == 1 || m_op == 2) ? !q_empty : 1'b0;
          m_ok  = legal;
          exp_q.push_back((legal && m_op != 0) ? q_root : '0);
          e_wrt   = legal && (m_op == 0 || m_op == 2);
          e_read  = legal && (m_op == 1 || m_op == 2);
          e_qdata = m_data;
          m_resp  = legal ? m_acc + 2 + GAP : m_acc + 2;
        end
        if (cyc == m_resp) begin
          e_rv = N'(1) << m_g;
          e_ok = m_ok;
          e_rd = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
          done = 1;
        end
      end
      chk("req_ready", req_ready, e_ready);
      chk("q_wrt", q_wrt, e_wrt);
      chk("q_read", q_read, e_read);
      chk("q_data", q_data_out, e_qdata);
      chk("rsp_valid", rsp_valid, e_rv);
      chk("rsp_ok", rsp_ok, e_ok);
      chk("rsp_data", rsp_data, e_rd);
      chk("busy", busy, m_active);
      if (done) m_active = 0;
      if (accept) begin
        m_active = 1;
        m_g      = w;
        m_op     = op_of(w);
        m_data   = data_of(w);
        m_acc    = cyc;
        m_resp   = -1;
        m_last   = w;
      end
    end
  endtask

  // compare on the falling edge, then return just after the next rising edge
  task automatic cycle_check();
    @(negedge clk);
    s_ready = req_ready; s_rv = rsp_valid; s_wrt = q_wrt; s_read = q_read;
    s_ok = rsp_ok; s_busy = busy; s_qdata = q_data_out; s_rd = rsp_data;
    model_cycle();
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input int op, input logic [DW-1:0] d);
    req_valid[i]         = 1'b1;
    req_op[2*i +: 2]     = op[1:0];
    req_data[DW*i +: DW] = d;
  endtask

  task automatic do_reset(input int cycles);
    rstn = 1'b0;
    repeat (cycles) cycle_check();
    rstn = 1'b1;
  endtask

  int acc_cyc[5];
  int acc_g[5];
  int rsp_cyc[5];
  int n_acc, n_rsp;

  initial begin
    rstn = 1'b0; req_valid = '0; req_op = '0; req_data = '0;
    q_full = 1'b0; q_empty = 1'b1; q_root = '0;
    m_active = 0; m_last = N - 1; m_resp = -1;
    do_reset(3);

    // post-reset idle
    cycle_check();
    chk("idle_busy", s_busy, 0);

    // enqueue on an empty tree
    set_req(1, 0, 16'h0100);
    cycle_check();
    chk("enq_ready", s_ready, 4'b0010);
    req_valid = '0;
    cycle_check();
    chk("enq_wrt", s_wrt, 1);
    chk("enq_read", s_read, 0);
    chk("enq_qdata", s_qdata, 16'h0100);
    repeat (GAP) cycle_check();
    chk("enq_early_rsp", s_rv, 0);
    cycle_check();
    chk("enq_rsp", s_rv, 4'b0010);
    chk("enq_ok", s_ok, 1);
    chk("enq_data", s_rd, 0);
    cycle_check();

    // dequeue on empty tree is rejected
    q_empty = 1'b1;
    set_req(0, 1, 16'h1234);
    cycle_check();
    req_valid = '0;
    cycle_check();
    chk("deq_no_strobe", {s_wrt, s_read}, 0);
    cycle_check();
    chk("deq_rsp", s_rv, 4'b0001);
    chk("deq_ok", s_ok, 0);
    chk("deq_data", s_rd, 0);
    cycle_check();

    // replace returns the old root
    q_empty = 1'b0; q_root = 16'd900;
    set_req(3, 2, 16'd5);
    cycle_check();
    chk("repl_ready", s_ready, 4'b1000);
    req_valid = '0;
    cycle_check();
    chk("repl_strobes", {s_wrt, s_read}, 2'b11);
    chk("repl_qdata", s_qdata, 16'd5);
    repeat (GAP) cycle_check();
    cycle_check();
    chk("repl_ok", s_ok, 1);
    chk("repl_data", s_rd, 16'd900);
    cycle_check();

    // rejects: enqueue on full tree, reserved op
    q_full = 1'b1;
    set_req(2, 0, 16'h00aa);
    cycle_check();
    req_valid = '0;
    cycle_check();
    chk("full_no_strobe", {s_wrt, s_read}, 0);
    cycle_check();
    chk("full_rsp", {s_rv, s_ok}, {4'b0100, 1'b0});
    q_full = 1'b0;
    set_req(1, 3, 16'h00bb);
    cycle_check();
    req_valid = '0;
    cycle_check();
    chk("rsvd_no_strobe", {s_wrt, s_read}, 0);
    cycle_check();
    chk("rsvd_rsp", {s_rv, s_ok}, {4'b0010, 1'b0});
    cycle_check();

    // fairness: everyone requests continuously from reset
    do_reset(1);
    for (int i = 0; i < N; i++) set_req(i, 3, DW'(i));
    n_acc = 0; n_rsp = 0;
    for (int c = 0; c < 16; c++) begin
      cycle_check();
      if (s_ready != 0 && n_acc < 5) begin
        acc_g[n_acc] = onehot_idx(s_ready); acc_cyc[n_acc] = cyc - 1; n_acc++;
      end
      if (s_rv != 0 && n_rsp < 5) begin
        rsp_cyc[n_rsp] = cyc - 1; n_rsp++;
      end
    end
    req_valid = '0;
    chk("fair_count", n_acc, 5);
    for (int k = 0; k < 5; k++) chk("fair_order", acc_g[k], k % N);
    for (int k = 1; k < 5; k++) chk("fair_spacing", acc_cyc[k], rsp_cyc[k-1] + 1);
    repeat (4) cycle_check();

    // reset in the middle of WAIT aborts silently
    set_req(1, 0, 16'h0042);
    cycle_check();
    req_valid = '0;
    repeat (6) cycle_check();
    do_reset(1);
    cycle_check();
    chk("abort_busy", s_busy, 0);
    chk("abort_rsp", s_rv, 0);
    set_req(0, 3, 16'h0001);
    set_req(2, 3, 16'h0002);
    cycle_check();
    chk("abort_next_grant", s_ready, 4'b0001);
    req_valid[0] = 1'b0;
    repeat (3) cycle_check();
    req_valid = '0;
    repeat (4) cycle_check();

    // randomized soak
    for (int c = 0; c < 4000; c++) begin
      int r;
      r = $urandom_range(0, 3);
      q_full  = (r == 0);
      q_empty = (r == 1);
      q_root  = DW'($urandom);
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 9) < 3)
          set_req(i, $urandom_range(0, 3), DW'($urandom));
      end
      if ($urandom_range(0, 799) == 0) rstn = 1'b0;
      else rstn = 1'b1;
      cycle_check();
      req_valid = req_valid & ~s_ready;
    end
    rstn = 1'b1;
    req_valid = '0;
    repeat (GAP + 4) cycle_check();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bram_tree_arbiter.md
BRAM_TREE_ARBITER -- requirements
Module: bram_tree_arbiter

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset, with ports named CLK and RSTn.
REQ-002 Parameter NUM_REQ, 4, SHALL set the number of requesters sharing one bram_tree instance.
REQ-003 Parameter DATA_WIDTH, 16, SHALL set the key width, equal to the tree's DATA_WIDTH.
REQ-004 Parameter OP_GAP, 24, SHALL set the idle cycles the tree needs after each wrt/read strobe.
REQ-005 CLK  input  1  clock, all logic on the rising edge.
REQ-006 RSTn  input  1  synchronous active-low reset.
REQ-007 i_req_valid  input  NUM_REQ  per-requester request valid.
REQ-008 i_req_op  input  2*NUM_REQ  per-requester op_t: 0 ENQUEUE, 1 DEQUEUE, 2 REPLACE, 3 reserved.
REQ-009 i_req_data  input  NUM_REQ*DATA_WIDTH  per-requester key.
REQ-010 o_req_ready  output  NUM_REQ  one-hot accept strobe.
REQ-011 o_rsp_valid  output  NUM_REQ  one-hot, single-cycle response strobe, no backpressure.
REQ-012 o_rsp_ok  output  1  the operation was executed (1) or rejected (0), valid with o_rsp_valid.
REQ-013 o_rsp_data  output  DATA_WIDTH  root key returned for DEQUEUE/REPLACE, else 0.
REQ-014 o_q_wrt, o_q_read  output  1 each  strobes to the tree's i_wrt and i_read.
REQ-015 o_q_data  output  DATA_WIDTH  key to the tree's i_data.
REQ-016 i_q_full, i_q_empty  input  1 each  from the tree's o_full and o_empty.
REQ-017 i_q_data  input  DATA_WIDTH  from the tree's o_data, the current root.
REQ-018 o_busy  output  1  high in every state except IDLE.

Function
REQ-019 The FSM SHALL have exactly four states: IDLE, ISSUE, WAIT, RESP.
REQ-020 In IDLE with any i_req_valid bit set, the block SHALL raise o_req_ready[g] combinationally for the round-robin winner g, latch op and data, and go to ISSUE.
REQ-021 The round-robin search SHALL start at (last_grant+1) mod NUM_REQ, and last_grant SHALL update only on accept.
REQ-022 In ISSUE, the block SHALL reject the request when: ENQUEUE with i_q_full=1, DEQUEUE or REPLACE with i_q_empty=1, or op=3.
REQ-023 In ISSUE for a legal request, the block SHALL assert for exactly one cycle: ENQUEUE wrt=1/read=0; DEQUEUE wrt=0/read=1; REPLACE wrt=1/read=1.
REQ-024 o_q_data SHALL carry the latched key during ISSUE and 0 otherwise.
REQ-025 In ISSUE, the block SHALL capture i_q_data as the response data for DEQUEUE/REPLACE, and use 0 for ENQUEUE.
REQ-026 A legal ISSUE SHALL go to WAIT, where a counter runs OP_GAP cycles, then go to RESP.
REQ-027 A rejected ISSUE SHALL go directly to RESP with no tree strobe.
REQ-028 RESP SHALL pulse o_rsp_valid[g] for one cycle with o_rsp_ok and o_rsp_data, then return to IDLE.
REQ-029 Latency SHALL be: accept at cycle T, strobe at T+1, legal response at T+2+OP_GAP, rejected response at T+2, next accept no earlier than the cycle after RESP.
REQ-030 o_req_ready SHALL be 0 in every state except IDLE, so requests arriving while busy are held, not dropped.
REQ-031 The WAIT counter SHALL be $clog2(OP_GAP+1) bits wide and SHALL NOT wrap.

Reset
REQ-032 While RSTn=0 at a clock edge, the block SHALL set state=IDLE, counter=0, and last_grant=NUM_REQ-1 so that requester 0 wins first.
REQ-033 While RSTn=0 at a clock edge, the block SHALL clear the latched op and data, and SHALL drive all outputs to 0.
REQ-034 A reset arriving in any state, including mid-WAIT, SHALL abort the operation without issuing a response.

Structure
REQ-035 op_t, the FSM state enum, and the OP_GAP default SHALL live in a shared package, bram_tree_pkg.
REQ-036 Round-robin selection SHALL be one sub-module, rr_arbiter (request vector and last grant in, one-hot grant out).

Verification
REQ-037 Enqueue: after reset, empty queue, req1 ENQUEUE 0x0100 at T -> ready[1] at T; wrt=1, read=0, o_q_data=0x0100 at T+1; rsp_valid[1], ok=1, data=0 at T+26.
REQ-038 Empty dequeue: i_q_empty=1, req0 DEQUEUE -> no strobe; rsp_valid[0], ok=0, data=0 at T+2.
REQ-039 Replace: i_q_data=900, req3 REPLACE 5 -> wrt=read=1 for one cycle with o_q_data=5; rsp ok=1, data=900.
REQ-040 Rejects: i_q_full=1 with ENQUEUE, and any op=3 -> ok=0, no strobe, response at T+2.
REQ-041 Fairness: all four requesters valid continuously -> grant order 0,1,2,3,0, each accept exactly one cycle after the previous RESP.
REQ-042 Mid-op reset: RSTn=0 in WAIT -> IDLE next cycle with all outputs 0 and no response; then req0 and req2 valid together -> req0 granted.
